// File: rtl/reg_arbiter.sv
// Two-requester round-robin arbiter onto a shared register bus with a
// fixed read latency; each transaction runs IDLE -> BUS (READ_LATENCY cycles) -> DONE.
module reg_arbiter #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_wr,
  input  logic [15:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_ack,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_wr,
  input  logic [15:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic [31:0] b_rdata,
  output logic [15:0] reg_addr,
  output logic [31:0] reg_wdata,
  output logic        reg_wr,
  input  logic [31:0] reg_rdata,
  output logic        busy,
  output logic        grant_b
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam logic [1:0] CNT_LOAD = 2'(READ_LATENCY - 1);

  state_t      state_q, state_d;
  logic        last_b_q, last_b_d;
  logic        grant_b_q, grant_b_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        first_q, first_d;
  logic [31:0] a_rdata_q, a_rdata_d;
  logic [31:0] b_rdata_q, b_rdata_d;
  logic        pick_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_b_q  <= 1'b1;
      grant_b_q <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_b_q  <= last_b_d;
      grant_b_q <= grant_b_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_b_d  = last_b_q;
    grant_b_d = grant_b_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    // B wins when alone, or when both ask and A was granted last
    pick_b    = b_req && (!a_req || !last_b_q);
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          grant_b_d = pick_b;
          last_b_d  = pick_b;
          wr_d      = pick_b ? b_wr    : a_wr;
          addr_d    = pick_b ? b_addr  : a_addr;
          wdata_d   = pick_b ? b_wdata : a_wdata;
          cnt_d     = CNT_LOAD;
          first_d   = 1'b1;
          state_d   = BUS;
        end
      end
      BUS: begin
        first_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = DONE;
          if (grant_b_q) b_rdata_d = reg_rdata;
          else           a_rdata_d = reg_rdata;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign grant_b   = grant_b_q;
  assign reg_addr  = (state_q == BUS) ? addr_q  : '0;
  assign reg_wdata = (state_q == BUS) ? wdata_q : '0;
  assign reg_wr    = (state_q == BUS) && first_q && wr_q;
  assign a_ack     = (state_q == DONE) && !grant_b_q;
  assign b_ack     = (state_q == DONE) &&  grant_b_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;

endmodule

// File: tb/tb_reg_arbiter.sv
// Bench for reg_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model, on instances with READ_LATENCY 1 and 3.
module tb_reg_arbiter;

  logic        clk = 1'b0;
  logic        reset, a_req, a_wr, b_req, b_wr;
  logic [15:0] a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata, reg_rdata;

  logic        o1_a_ack, o1_b_ack, o1_reg_wr, o1_busy, o1_grant_b;
  logic [31:0] o1_a_rdata, o1_b_rdata, o1_reg_wdata;
  logic [15:0] o1_reg_addr;
  logic        o3_a_ack, o3_b_ack, o3_reg_wr, o3_busy, o3_grant_b;
  logic [31:0] o3_a_rdata, o3_b_rdata, o3_reg_wdata;
  logic [15:0] o3_reg_addr;

  logic        use3 = 1'b0;
  logic        a_ack, b_ack, reg_wr, busy, grant_b;
  logic [31:0] a_rdata, b_rdata, reg_wdata;
  logic [15:0] reg_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reg_arbiter #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(o1_a_ack), .a_rdata(o1_a_rdata),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(o1_b_ack), .b_rdata(o1_b_rdata),
    .reg_addr(o1_reg_addr), .reg_wdata(o1_reg_wdata), .reg_wr(o1_reg_wr),
    .reg_rdata(reg_rdata), .busy(o1_busy), .grant_b(o1_grant_b)
  );

  reg_arbiter #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(o3_a_ack), .a_rdata(o3_a_rdata),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(o3_b_ack), .b_rdata(o3_b_rdata),
    .reg_addr(o3_reg_addr), .reg_wdata(o3_reg_wdata), .reg_wr(o3_reg_wr),
    .reg_rdata(reg_rdata), .busy(o3_busy), .grant_b(o3_grant_b)
  );

  assign a_ack     = use3 ? o3_a_ack     : o1_a_ack;
  assign b_ack     = use3 ? o3_b_ack     : o1_b_ack;
  assign reg_wr    = use3 ? o3_reg_wr    : o1_reg_wr;
  assign busy      = use3 ? o3_busy      : o1_busy;
  assign grant_b   = use3 ? o3_grant_b   : o1_grant_b;
  assign a_rdata   = use3 ? o3_a_rdata   : o1_a_rdata;
  assign b_rdata   = use3 ? o3_b_rdata   : o1_b_rdata;
  assign reg_wdata = use3 ? o3_reg_wdata : o1_reg_wdata;
  assign reg_addr  = use3 ? o3_reg_addr  : o1_reg_addr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_req = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_wr = 0; b_addr = '0; b_wdata = '0;
    reg_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    use3 = 0;
    do_reset();
    n_tests++;
    if ({busy, a_ack, b_ack, reg_wr, grant_b} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b exp 00000", {busy, a_ack, b_ack, reg_wr, grant_b});
    end
    n_tests++;
    if ({a_rdata, b_rdata, reg_addr, reg_wdata} !== 112'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h %h exp zeros", a_rdata, b_rdata, reg_addr, reg_wdata);
    end
  endtask

  task automatic test_read_a();
    use3 = 0;
    do_reset();
    a_req = 1; a_wr = 0; a_addr = 16'h0010;
    tick();
    reg_rdata = 32'hDEADBEEF;
    n_tests++;
    if (reg_addr !== 16'h0010 || reg_wr !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL read_a_bus: got addr=%h wr=%b busy=%b exp 0010 0 1", reg_addr, reg_wr, busy);
    end
    tick();
    n_tests++;
    if (a_ack !== 1'b1 || b_ack !== 1'b0 || a_rdata !== 32'hDEADBEEF || reg_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL read_a_ack: got ack=%b/%b rdata=%h wr=%b exp 1/0 deadbeef 0", a_ack, b_ack, a_rdata, reg_wr);
    end
    a_req = 0;
    tick();
    n_tests++;
    if (a_ack !== 1'b0 || busy !== 1'b0 || reg_addr !== 16'h0) begin
      n_fail++;
      $display("FAIL read_a_idle: got ack=%b busy=%b addr=%h exp 0 0 0000", a_ack, busy, reg_addr);
    end
  endtask

  task automatic test_write_b();
    use3 = 0;
    do_reset();
    b_req = 1; b_wr = 1; b_addr = 16'h0003; b_wdata = 32'h12345678;
    tick();
    reg_rdata = 32'h0BADF00D;
    n_tests++;
    if (reg_wr !== 1'b1 || reg_addr !== 16'h0003 || reg_wdata !== 32'h12345678 || grant_b !== 1'b1) begin
      n_fail++;
      $display("FAIL write_b_bus: got wr=%b addr=%h data=%h gnt=%b exp 1 0003 12345678 1", reg_wr, reg_addr, reg_wdata, grant_b);
    end
    tick();
    n_tests++;
    if (b_ack !== 1'b1 || a_ack !== 1'b0 || reg_wr !== 1'b0 || b_rdata !== 32'h0BADF00D || a_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL write_b_ack: got ack=%b/%b wr=%b brd=%h ard=%h exp 1/0 0 0badf00d 0", b_ack, a_ack, reg_wr, b_rdata, a_rdata);
    end
    b_req = 0;
    tick();
  endtask

  task automatic test_round_robin();
    use3 = 0;
    do_reset();
    a_req = 1; b_req = 1; a_addr = 16'h00AA; b_addr = 16'h00BB;
    for (int c = 1; c <= 12; c++) begin
      tick();
      n_tests++;
      if (a_ack !== (c % 6 == 2) || b_ack !== (c % 6 == 5)) begin
        n_fail++;
        $display("FAIL round_robin c=%0d: got a_ack=%b b_ack=%b exp %b %b", c, a_ack, b_ack, (c % 6 == 2), (c % 6 == 5));
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_latency3();
    use3 = 1;
    do_reset();
    a_req = 1; a_wr = 0; a_addr = 16'h0020;
    reg_rdata = 32'hA0000000;
    for (int c = 1; c <= 3; c++) begin
      tick();
      reg_rdata = 32'hA0000000 + 32'(c);
      n_tests++;
      if (reg_addr !== 16'h0020 || a_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL lat3_hold c=%0d: got addr=%h ack=%b exp 0020 0", c, reg_addr, a_ack);
      end
    end
    tick();
    n_tests++;
    if (a_ack !== 1'b1 || a_rdata !== 32'hA0000003) begin
      n_fail++;
      $display("FAIL lat3_ack: got ack=%b rdata=%h exp 1 a0000003", a_ack, a_rdata);
    end
    clear_inputs();
    tick();
    use3 = 0;
  endtask

  task automatic test_reset_abort();
    use3 = 0;
    do_reset();
    a_req = 1; a_wr = 0; a_addr = 16'h0001;
    tick();
    reg_rdata = 32'h5555AAAA;
    tick();
    a_req = 0;
    tick();
    a_req = 1; a_wr = 1; a_addr = 16'h0044; a_wdata = 32'hCAFEF00D;
    tick();
    n_tests++;
    if (reg_wr !== 1'b1 || a_rdata !== 32'h5555AAAA) begin
      n_fail++;
      $display("FAIL abort_setup: got wr=%b rdata=%h exp 1 5555aaaa", reg_wr, a_rdata);
    end
    reset = 1;
    tick();
    n_tests++;
    if (busy !== 1'b0 || a_ack !== 1'b0 || a_rdata !== 32'h0 || reg_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: got busy=%b ack=%b rdata=%h wr=%b exp 0 0 0 0", busy, a_ack, a_rdata, reg_wr);
    end
    reset = 0;
    a_wr = 0; a_addr = 16'h0055;
    b_req = 1; b_addr = 16'h0066;
    tick();
    n_tests++;
    if (grant_b !== 1'b0 || reg_addr !== 16'h0055) begin
      n_fail++;
      $display("FAIL abort_regrant: got gnt=%b addr=%h exp 0 0055", grant_b, reg_addr);
    end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_late_b();
    use3 = 0;
    do_reset();
    a_req = 1; a_addr = 16'h0007;
    tick();
    b_req = 1; b_addr = 16'h0008;
    tick();
    n_tests++;
    if (a_ack !== 1'b1 || b_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL late_b_a: got a_ack=%b b_ack=%b exp 1 0", a_ack, b_ack);
    end
    a_req = 0;
    tick();
    n_tests++;
    if (busy !== 1'b0 || b_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL late_b_idle: got busy=%b b_ack=%b exp 0 0", busy, b_ack);
    end
    tick();
    n_tests++;
    if (grant_b !== 1'b1 || reg_addr !== 16'h0008) begin
      n_fail++;
      $display("FAIL late_b_bus: got gnt=%b addr=%h exp 1 0008", grant_b, reg_addr);
    end
    tick();
    n_tests++;
    if (b_ack !== 1'b1 || a_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL late_b_ack: got b_ack=%b a_ack=%b exp 1 0", b_ack, a_ack);
    end
    b_req = 0;
    tick();
  endtask

  // Transaction-level model: a grant at cycle s owns the bus in s+1..s+rl and
  // acks at s+rl+1; the arbiter samples again from s+rl+2.
  task automatic test_random(input int rl, input int ncyc);
    bit          active = 0, own_b = 0, t_wr = 0, last_b = 1, g_b = 0, pa = 0, pb = 0;
    bit          in_bus, in_done;
    int          start = 0;
    logic [15:0] t_addr = '0, e_addr;
    logic [31:0] t_wdata = '0, m_ra = '0, m_rb = '0, e_wdata;
    logic [4:0]  e_flags;
    use3 = (rl == 3);
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      in_bus  = active && c > start && c <= start + rl;
      in_done = active && c == start + rl + 1;
      e_flags = {in_bus || in_done, in_bus && c == start + 1 && t_wr,
                 in_done && !own_b, in_done && own_b, g_b};
      e_addr  = in_bus ? t_addr  : 16'h0;
      e_wdata = in_bus ? t_wdata : 32'h0;
      n_tests++;
      if ({busy, reg_wr, a_ack, b_ack, grant_b} !== e_flags) begin
        n_fail++;
        $display("FAIL rand%0d_flags c=%0d: got %b exp %b", rl, c, {busy, reg_wr, a_ack, b_ack, grant_b}, e_flags);
      end
      n_tests++;
      if (reg_addr !== e_addr || reg_wdata !== e_wdata) begin
        n_fail++;
        $display("FAIL rand%0d_bus c=%0d: got %h/%h exp %h/%h", rl, c, reg_addr, reg_wdata, e_addr, e_wdata);
      end
      n_tests++;
      if (a_rdata !== m_ra || b_rdata !== m_rb) begin
        n_fail++;
        $display("FAIL rand%0d_rdata c=%0d: got %h/%h exp %h/%h", rl, c, a_rdata, b_rdata, m_ra, m_rb);
      end
      if (in_done && !own_b) pa = 0;
      if (in_done &&  own_b) pb = 0;
      if (!pa && $urandom_range(0, 2) == 0) begin
        pa = 1; a_wr = 1'($urandom); a_addr = 16'($urandom); a_wdata = $urandom;
      end
      if (!pb && $urandom_range(0, 2) == 0) begin
        pb = 1; b_wr = 1'($urandom); b_addr = 16'($urandom); b_wdata = $urandom;
      end
      a_req = pa;
      b_req = pb;
      reg_rdata = $urandom;
      if (in_bus && c == start + rl) begin
        if (own_b) m_rb = reg_rdata;
        else       m_ra = reg_rdata;
      end
      if ((!active || c > start + rl + 1) && (a_req || b_req)) begin
        own_b   = b_req && (!a_req || !last_b);
        last_b  = own_b;
        g_b     = own_b;
        t_wr    = own_b ? b_wr    : a_wr;
        t_addr  = own_b ? b_addr  : a_addr;
        t_wdata = own_b ? b_wdata : a_wdata;
        active  = 1;
        start   = c;
      end
      tick();
    end
    clear_inputs();
    tick();
    tick();
    tick();
    tick();
    tick();
    use3 = 0;
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_read_a();
    test_write_b();
    test_round_robin();
    test_latency3();
    test_reset_abort();
    test_late_b();
    test_random(1, 400);
    test_random(3, 400);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_arbiter.md
REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 The block SHALL have parameter READ_LATENCY, default 1, giving the number of bus cycles from address presentation to valid reg_rdata (legal range 1..4).
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 a_req  input  1  requester A transaction request (level).
REQ-005 a_wr  input  1  requester A: 1 = write, 0 = read.
REQ-006 a_addr  input  16  requester A register address.
REQ-007 a_wdata  input  32  requester A write data.
REQ-008 a_ack  output  1  one-cycle completion pulse to A.
REQ-009 a_rdata  output  32  read-back data for A's last completed transaction.
REQ-010 b_req, b_wr, b_addr, b_wdata, b_ack, b_rdata SHALL mirror REQ-004..REQ-009 for requester B.
REQ-011 reg_addr  output  16  shared register bus address.
REQ-012 reg_wdata  output  32  shared register bus write data.
REQ-013 reg_wr  output  1  shared register bus write strobe.
REQ-014 reg_rdata  input  32  shared register bus read data.
REQ-015 busy  output  1  high whenever the state is not IDLE.
REQ-016 grant_b  output  1  owner of current/last transaction: 0 = A, 1 = B.

Function
REQ-017 States: IDLE, BUS, DONE; encoding free.
REQ-018 In IDLE, if a_req or b_req is sampled high, the arbiter SHALL latch the winner's wr/addr/wdata, set grant_b, load the bus counter with READ_LATENCY-1 and enter BUS on the next edge.
REQ-019 Round-robin priority: if exactly one req is high, that requester wins; if both are high, the requester not granted last wins.
REQ-020 The last-grant record SHALL reset to B, so A wins the first simultaneous request.
REQ-021 Requests SHALL be sampled only in IDLE; req changes during BUS/DONE SHALL be ignored.
REQ-022 During BUS, reg_addr and reg_wdata SHALL carry the latched values, held stable for all READ_LATENCY cycles.
REQ-023 reg_wr SHALL be high only in the first BUS cycle, and only if the latched wr is 1.
REQ-024 BUS SHALL last exactly READ_LATENCY cycles; on its final edge reg_rdata SHALL be captured into the owner's rdata register (for writes too) and the state SHALL go to DONE.
REQ-025 The non-owner's rdata register SHALL remain unchanged.
REQ-026 In DONE, the owner's ack SHALL be high for exactly one cycle; the state SHALL then return to IDLE.
REQ-027 The requester SHALL drop req on the edge at which it samples ack high; a req still high in IDLE after DONE is a new request.
REQ-028 Latency: req first sampled in IDLE at cycle 0 -> BUS cycles 1..READ_LATENCY -> ack in cycle READ_LATENCY+1; minimum back-to-back period is READ_LATENCY+2 cycles.
REQ-029 Outside BUS, reg_addr and reg_wdata SHALL be 0 and reg_wr SHALL be 0.
REQ-030 a_ack and b_ack SHALL never be high in the same cycle.

Reset
REQ-031 When reset is high at a clock edge, the state SHALL become IDLE, the last-grant record B and grant_b 0.
REQ-032 On the same edge, a_rdata and b_rdata SHALL become 0 and all strobes (a_ack, b_ack, reg_wr, busy) SHALL be 0.
REQ-033 Reset during BUS or DONE SHALL abort the transaction with no ack and no rdata update.
REQ-034 reset SHALL take priority over all other inputs.

Verification (READ_LATENCY=1 unless stated)
REQ-035 A read: a_req=1, a_wr=0, a_addr=0x0010, reg_rdata=0xDEADBEEF -> reg_addr=0x0010 in cycle 1; a_ack in cycle 2; a_rdata=0xDEADBEEF; reg_wr never high.
REQ-036 B write: b_addr=0x0003, b_wdata=0x12345678 -> reg_wr high for exactly cycle 1 with that addr/data; b_ack in cycle 2; grant_b=1.
REQ-037 Simultaneous a_req and b_req after reset, both held -> order is A, B, A, B; acks never overlap; each period is 3 cycles.
REQ-038 READ_LATENCY=3, A read with reg_rdata changing each cycle -> addr held in cycles 1-3; a_rdata equals reg_rdata in cycle 3; a_ack in cycle 4.
REQ-039 Reset asserted in the BUS cycle of an A write -> next cycle: IDLE, busy=0, no a_ack, a_rdata=0; the following simultaneous request is granted to A.
REQ-040 b_req rising while A is in BUS -> B is not served until IDLE; b_ack comes 3 cycles after a_ack.
